// File: rtl/alu.sv
// 4-bit registered ALU with NZCV flags and an active-low 7-segment readout.
// Define ALU_DISPLAY_EN to build the hex decoder; otherwise display is tied off.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       ALU_Code,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALU_Result,
  output logic [3:0]       flags,
  output logic [6:0]       display
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_flags;
  logic [WIDTH-1:0] r_res;
  logic [3:0]       r_flags;

  // Subtraction as A + ~B + 1 so the carry-out reads as "no borrow".
  assign w_sum = {1'b0, A} + {1'b0, B};
  assign w_dif = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (ALU_Code)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SHL: begin
        w_res = {A[WIDTH-2:0], 1'b0};
        w_c   = A[WIDTH-1];
      end
      OP_SHR: begin
        w_res = {1'b0, A[WIDTH-1:1]};
        w_c   = A[0];
      end
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      default: w_res = '0;
    endcase
  end

  assign w_flags = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res   <= '0;
      r_flags <= 4'b0000;
    end else begin
      r_res   <= w_res;
      r_flags <= w_flags;
    end
  end

  assign ALU_Result = r_res;
  assign flags      = r_flags;

`ifdef ALU_DISPLAY_EN
  logic [6:0] w_seg;
  logic [6:0] r_seg;

  // Segment order {g,f,e,d,c,b,a}, 0 = lit; b and d use lowercase glyphs.
  always_comb begin
    w_seg = 7'b1111111;
    case (w_res[3:0])
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      4'hF: w_seg = 7'b0001110;
      default: w_seg = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_seg <= 7'b1000000;
    else        r_seg <= w_seg;
  end

  assign display = r_seg;
`else
  assign display = 7'b1111111;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: reset, opcode vectors, latency and mid-cycle glitching.
module tb_alu;
  logic       clk;
  logic       rst_n;
  logic [2:0] ALU_Code;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] ALU_Result;
  logic [3:0] flags;
  logic [6:0] display;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ALU_DISPLAY_EN
  localparam bit DISP = 1'b1;
`else
  localparam bit DISP = 1'b0;
`endif

  // Hand-written active-low glyphs {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  alu #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ALU_Code(ALU_Code), .A(A), .B(B),
    .ALU_Result(ALU_Result), .flags(flags), .display(display));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] er, input logic [3:0] ef,
                     input logic [6:0] ed);
    logic [6:0] xd;
    xd = DISP ? ed : 7'b1111111;
    n_cmp++;
    assert (ALU_Result === er) else begin
      n_err++; $error("FAIL %s result got %b want %b", tag, ALU_Result, er);
    end
    n_cmp++;
    assert (flags === ef) else begin
      n_err++; $error("FAIL %s flags got %b want %b", tag, flags, ef);
    end
    n_cmp++;
    assert (display === xd) else begin
      n_err++; $error("FAIL %s display got %b want %b", tag, display, xd);
    end
  endtask

  // Drive, capture on the next edge, check, then glitch inputs and recheck.
  task automatic step(input string tag, input logic [2:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] er, input logic [3:0] ef);
    ALU_Code = op; A = a; B = b;
    @(posedge clk); #1;
    chk(tag, er, ef, SEG[er]);
    ALU_Code = ~op; A = ~a; B = ~b;
    #2;
    chk({tag, "_glitch"}, er, ef, SEG[er]);
  endtask

  initial begin
    rst_n = 1'b1; ALU_Code = 3'b000; A = 4'h0; B = 4'h0;
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 4'h0, 4'h0, 7'b1000000);
    ALU_Code = 3'b000; A = 4'b0101; B = 4'b1001;
    @(posedge clk); #1;
    chk("reset_hold", 4'h0, 4'h0, 7'b1000000);
    #3 rst_n = 1'b1;

    step("add_5_9", 3'b000, 4'b0101, 4'b1001, 4'b1110, 4'b1000);
    step("sub_5_9", 3'b001, 4'b0101, 4'b1001, 4'b1100, 4'b1001);
    step("and_5_9", 3'b100, 4'b0101, 4'b1001, 4'b0001, 4'b0000);
    step("or_5_9",  3'b101, 4'b0101, 4'b1001, 4'b1101, 4'b1000);
    step("xor_5_9", 3'b110, 4'b0101, 4'b1001, 4'b1100, 4'b1000);

    step("add_d_d", 3'b000, 4'b1101, 4'b1101, 4'b1010, 4'b1010);
    step("sub_d_d", 3'b001, 4'b1101, 4'b1101, 4'b0000, 4'b0110);
    step("shl_d",   3'b010, 4'b1101, 4'b1101, 4'b1010, 4'b1010);
    step("shr_d",   3'b011, 4'b1101, 4'b1101, 4'b0110, 4'b0010);

    step("sub_1_0", 3'b001, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    step("and_1_0", 3'b100, 4'b0001, 4'b0000, 4'b0000, 4'b0100);
    step("zero_op", 3'b111, 4'b0001, 4'b0000, 4'b0000, 4'b0100);

    // Back-to-back opcode changes with A=0110, B=0011.
    step("lat_add", 3'b000, 4'b0110, 4'b0011, 4'b1001, 4'b1001);
    step("lat_sub", 3'b001, 4'b0110, 4'b0011, 4'b0011, 4'b0010);
    step("lat_shl", 3'b010, 4'b0110, 4'b0011, 4'b1100, 4'b1000);
    step("lat_shr", 3'b011, 4'b0110, 4'b0011, 4'b0011, 4'b0000);
    step("lat_and", 3'b100, 4'b0110, 4'b0011, 4'b0010, 4'b0000);
    step("lat_or",  3'b101, 4'b0110, 4'b0011, 4'b0111, 4'b0000);
    step("lat_xor", 3'b110, 4'b0110, 4'b0011, 4'b0101, 4'b0000);
    step("lat_zero",3'b111, 4'b0110, 4'b0011, 4'b0000, 4'b0100);
    step("add_ovf", 3'b000, 4'b0111, 4'b0001, 4'b1000, 4'b1001);
    step("sub_ovf", 3'b001, 4'b1000, 4'b0001, 4'b0111, 4'b0011);

    // Mid-stream reset drops the pending capture.
    ALU_Code = 3'b000; A = 4'b1101; B = 4'b1101;
    #1 rst_n = 1'b0;
    #1 chk("reset_mid", 4'h0, 4'h0, 7'b1000000);
    @(posedge clk); #1;
    chk("reset_mid_hold", 4'h0, 4'h0, 7'b1000000);
    #2 rst_n = 1'b1;
    step("post_reset", 3'b101, 4'b1010, 4'b0100, 4'b1110, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
